// File: rtl/btn_ctrl_pkg.sv
// rtl/btn_ctrl_pkg.sv - shared state encoding and timing derivation for the button controller
//
// Purpose: FSM state constants plus helpers that turn clock/rate parameters
//          into debounce and long-press cycle counts.
// Contents: ST_IDLE, ST_PRESS_CHK, ST_HELD, ST_REL_CHK (2-bit encodings);
//           calc_db_cnt(clk_in, debounce_hz)        -> max(1, clk_in/debounce_hz)
//           calc_long_cnt(clk_in, long_hz, db_cnt)  -> max(db_cnt+1, clk_in/long_hz)
package btn_ctrl_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PRESS_CHK = 2'd1;
    localparam logic [1:0] ST_HELD      = 2'd2;
    localparam logic [1:0] ST_REL_CHK   = 2'd3;

    function automatic int calc_db_cnt(input int clk_in, input int debounce_hz);
        int c;
        c = clk_in / debounce_hz;
        return (c < 1) ? 1 : c;
    endfunction

    // The long-press threshold must lie beyond the point where HELD starts
    // counting (DB_CNT), otherwise o_long could coincide with o_press.
    function automatic int calc_long_cnt(input int clk_in, input int long_hz, input int db_cnt);
        int c;
        c = clk_in / long_hz;
        return (c < db_cnt + 1) ? db_cnt + 1 : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for a single asynchronous input
//
// Purpose: bring an asynchronous level into the i_clk domain.
// Ports:   i_clk   - destination clock (rising edge)
//          i_reset - asynchronous active-high reset, clears both flops
//          i_d     - asynchronous input level
//          o_q     - synchronized level (two cycles of latency)
module sync_2ff (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic meta_q;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            meta_q <= 1'b0;
            o_q    <= 1'b0;
        end else begin
            meta_q <= i_d;
            o_q    <= meta_q;
        end
    end

endmodule

// File: rtl/btn_toggle_ctrl.sv
// rtl/btn_toggle_ctrl.sv - debounced push-button toggle with long-press detection
//
// Purpose: debounce a raw button, toggle an enable level on each press and
//          force the enable off when the press is held long enough.
// Ports:   i_clk   - single clock, rising edge
//          i_reset - asynchronous active-high reset
//          i_btn   - raw bouncing button level (1 = pressed)
//          o_en    - registered enable level for the downstream LED blinker
//          o_press - one-cycle pulse per debounced press
//          o_long  - one-cycle pulse when a press has been held LONG_CNT cycles
module btn_toggle_ctrl #(
    parameter int CLK_IN      = 300,
    parameter int DEBOUNCE_HZ = 100,
    parameter int LONG_HZ     = 10
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_en,
    output logic o_press,
    output logic o_long
);

    import btn_ctrl_pkg::*;

    localparam int DB_CNT   = calc_db_cnt(CLK_IN, DEBOUNCE_HZ);
    localparam int LONG_CNT = calc_long_cnt(CLK_IN, LONG_HZ, DB_CNT);
    localparam int CW       = $clog2(LONG_CNT + 1);

    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DB_CNT - 1);
    localparam logic [CW-1:0] DB_LOAD   = CW'(DB_CNT);
    localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_CNT);
    localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CNT - 1);

    logic          btn_s;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic [CW-1:0] hold_cnt_q, hold_cnt_d;
    logic          en_q, en_d;
    logic          press_q, press_d;
    logic          long_q, long_d;

    sync_2ff u_sync_btn (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_d     (i_btn),
        .o_q     (btn_s)
    );

    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        en_d       = en_q;
        press_d    = 1'b0;
        long_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                db_cnt_d   = '0;
                hold_cnt_d = '0;
                if (btn_s) begin
                    state_d  = ST_PRESS_CHK;
                    db_cnt_d = CNT_ONE;
                end
            end
            ST_PRESS_CHK: begin
                // ">=" keeps DB_CNT = 1 working: the count is already 1 on entry.
                if (!btn_s) begin
                    state_d  = ST_IDLE;
                    db_cnt_d = '0;
                end else if (db_cnt_q >= DB_LAST) begin
                    state_d    = ST_HELD;
                    hold_cnt_d = DB_LOAD;
                    press_d    = 1'b1;
                    en_d       = ~en_q;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                // Saturating count: the threshold is crossed only once per press,
                // even across release glitches that bounce through REL_CHK.
                if (hold_cnt_q != LONG_MAX) begin
                    hold_cnt_d = hold_cnt_q + CNT_ONE;
                    if (hold_cnt_q == LONG_LAST) begin
                        long_d = 1'b1;
                        en_d   = 1'b0;
                    end
                end
                if (!btn_s) begin
                    state_d  = ST_REL_CHK;
                    db_cnt_d = CNT_ONE;
                end
            end
            ST_REL_CHK: begin
                // hold_cnt is retained so a release glitch does not restart timing.
                if (btn_s) begin
                    state_d = ST_HELD;
                end else if (db_cnt_q >= DB_LAST) begin
                    state_d    = ST_IDLE;
                    db_cnt_d   = '0;
                    hold_cnt_d = '0;
                end else begin
                    db_cnt_d = db_cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            en_q       <= 1'b0;
            press_q    <= 1'b0;
            long_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            en_q       <= en_d;
            press_q    <= press_d;
            long_q     <= long_d;
        end
    end

    assign o_en    = en_q;
    assign o_press = press_q;
    assign o_long  = long_q;

endmodule

// File: doc/btn_toggle_ctrl.md
BTN_TOGGLE_CTRL -- requirements
Module: btn_toggle_ctrl

Interface
REQ-001 SHALL have parameter CLK_IN, default 300: input clock frequency, Hz.
REQ-002 SHALL have parameter DEBOUNCE_HZ, default 100: reciprocal of debounce window; DB_CNT = max(1, CLK_IN/DEBOUNCE_HZ) cycles.
REQ-003 SHALL have parameter LONG_HZ, default 10: reciprocal of long-press time; LONG_CNT = max(DB_CNT+1, CLK_IN/LONG_HZ) cycles.
REQ-004 SHALL have port i_clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port i_reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port i_btn  input  1  raw, asynchronous, bouncing push-button level (1 = pressed).
REQ-007 SHALL have port o_en  output  1  registered enable level; drives i_en of the downstream LED blinker.
REQ-008 SHALL have port o_press  output  1  one-cycle pulse per debounced press.
REQ-009 SHALL have port o_long  output  1  one-cycle pulse when a press is held LONG_CNT cycles.

Function
REQ-010 SHALL pass i_btn through a 2-flop synchronizer; only the synchronized level (btn_s) SHALL feed the FSM.
REQ-011 SHALL implement FSM states IDLE, PRESS_CHK, HELD, REL_CHK with a debounce counter db_cnt and a hold counter hold_cnt.
REQ-012 IDLE: btn_s=1 -> PRESS_CHK, db_cnt<=1; else stay.
REQ-013 PRESS_CHK: btn_s=0 -> IDLE, db_cnt<=0; btn_s=1 and db_cnt=DB_CNT-1 -> HELD; else db_cnt increments.
REQ-014 On PRESS_CHK->HELD, o_press SHALL be 1 for exactly the next cycle and o_en SHALL toggle in that same cycle; hold_cnt<=DB_CNT.
REQ-015 Latency: o_press high exactly 2+DB_CNT rising edges after the first edge sampling i_btn=1, given i_btn stays stable.
REQ-016 HELD: hold_cnt increments, saturating at LONG_CNT; on reaching LONG_CNT, o_long SHALL pulse one cycle and o_en SHALL be forced 0 (once per press).
REQ-017 HELD: btn_s=0 -> REL_CHK, db_cnt<=1.
REQ-018 REL_CHK: btn_s=1 -> HELD, hold_cnt retained (release glitch does not restart long-press timing); btn_s=0 and db_cnt=DB_CNT-1 -> IDLE; else db_cnt increments.
REQ-019 Bounces shorter than DB_CNT cycles in PRESS_CHK or REL_CHK SHALL produce no o_press, no o_long, no o_en change.
REQ-020 o_press and o_long SHALL never assert in the same cycle; o_long SHALL assert at most once per IDLE->IDLE press cycle.
REQ-021 Counters SHALL be sized clog2(LONG_CNT+1) bits and SHALL never wrap.

Reset
REQ-022 i_reset=1 SHALL asynchronously force state IDLE, db_cnt=0, hold_cnt=0, synchronizer flops=0, o_en=0, o_press=0, o_long=0.
REQ-023 Reset asserted mid-press SHALL discard the press; after release of reset with i_btn still high, a fresh full debounce SHALL be required before o_press.

Structure
REQ-024 State encoding constants and DB_CNT/LONG_CNT derivation SHALL live in shared package btn_ctrl_pkg.
REQ-025 Synchronizer SHALL be sub-module sync_2ff (i_clk, i_reset, i_d, o_q), reusable for other asynchronous inputs.

Verification (CLK_IN=300, DEBOUNCE_HZ=100 -> DB_CNT=3, LONG_HZ=10 -> LONG_CNT=30)
REQ-026 Reset held 10 cycles, i_btn=0 -> o_en=o_press=o_long=0 throughout and after release.
REQ-027 Clean press, i_btn=1 for 10 cycles then 0 -> single o_press pulse 5 edges after rise, o_en 0->1; after release no further change.
REQ-028 Bounce 1-0-1-0 (1-cycle pulses) then steady 1 for 8 cycles -> exactly one o_press, timed from start of steady level; second identical press -> o_en 1->0.
REQ-029 Hold i_btn=1 for 40 cycles from o_en=0 -> o_press then o_long 27 cycles later; o_en 0->1->0; no second o_long.
REQ-030 Press, 1-cycle release glitch at hold_cnt=20, continue holding -> no extra o_press, o_long still 10 cycles after glitch point.
REQ-031 Async reset asserted 2 cycles into PRESS_CHK while i_btn=1, released with i_btn=1 -> o_press occurs 5 edges after reset release, o_en=1.
